// File: rtl/sad_search_ctrl.sv
// Search controller for the SAD 4x8 datapath: walks the candidate list, drives
// the init/ack handshake, keeps the running minimum and guards with a watchdog.
module sad_search_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TMO   = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W:0]     num_cand,
    input  logic               host_ack,
    input  logic               sad_done,
    input  logic [WIDTH+4:0]   sad_value,
    output logic               sad_init,
    output logic               sad_ack,
    output logic [IDX_W-1:0]   cand_idx,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [WIDTH+4:0]   best_sad,
    output logic [IDX_W-1:0]   best_idx
);

    localparam int unsigned SW   = WIDTH + 5;
    localparam int unsigned WD_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CMP,
        REL,
        DONE
    } state_t;

    state_t            state_q,    state_d;
    logic [IDX_W:0]    cnt_max_q,  cnt_max_d;
    logic [IDX_W-1:0]  cand_idx_q, cand_idx_d;
    logic [SW-1:0]     best_sad_q, best_sad_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic              err_q,      err_d;
    logic [WD_W-1:0]   wdog_q,     wdog_d;
    logic              last_cand;

    // Compare at IDX_W+1 bits so num_cand = 2^IDX_W ends on the all-ones index.
    assign last_cand = (({1'b0, cand_idx_q} + (IDX_W + 1)'(1)) == cnt_max_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_max_q  <= '0;
            cand_idx_q <= '0;
            best_sad_q <= '1;
            best_idx_q <= '0;
            err_q      <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_max_q  <= cnt_max_d;
            cand_idx_q <= cand_idx_d;
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
            err_q      <= err_d;
            wdog_q     <= wdog_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_max_d  = cnt_max_q;
        cand_idx_d = cand_idx_q;
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
        err_d      = err_q;
        wdog_d     = wdog_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_max_d  = num_cand;
                    cand_idx_d = '0;
                    best_sad_d = '1;
                    best_idx_d = '0;
                    err_d      = 1'b0;
                    state_d    = (num_cand == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                wdog_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                if (sad_done) begin
                    state_d = CMP;
                end else if (wdog_q == WD_W'(TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            CMP: begin
                if (sad_value < best_sad_q) begin
                    best_sad_d = sad_value;
                    best_idx_d = cand_idx_q;
                end
                state_d = REL;
            end
            REL: begin
                if (!sad_done) begin
                    if (last_cand) begin
                        state_d = DONE;
                    end else begin
                        cand_idx_d = cand_idx_q + IDX_W'(1);
                        state_d    = LOAD;
                    end
                end
            end
            DONE: begin
                if (host_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sad_init = (state_q == RUN);
        sad_ack  = (state_q == CMP) || (state_q == REL);
        busy     = (state_q == LOAD) || (state_q == RUN) ||
                   (state_q == CMP)  || (state_q == REL);
        done     = (state_q == DONE);
        err      = err_q;
        cand_idx = cand_idx_q;
        best_sad = best_sad_q;
        best_idx = best_idx_q;
    end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl with a small behavioural datapath model
// (configurable latency, hang candidate and post-ack hold of sad_done).
module tb_sad_search_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned TMO   = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IDX_W:0]    num_cand;
    logic              host_ack;
    logic              sad_done = 1'b0;
    logic [WIDTH+4:0]  sad_value = '0;
    logic              sad_init;
    logic              sad_ack;
    logic [IDX_W-1:0]  cand_idx;
    logic              busy;
    logic              done;
    logic              err;
    logic [WIDTH+4:0]  best_sad;
    logic [IDX_W-1:0]  best_idx;

    sad_search_ctrl #(.WIDTH(WIDTH), .IDX_W(IDX_W), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .num_cand(num_cand),
        .host_ack(host_ack), .sad_done(sad_done), .sad_value(sad_value),
        .sad_init(sad_init), .sad_ack(sad_ack), .cand_idx(cand_idx),
        .busy(busy), .done(done), .err(err), .best_sad(best_sad),
        .best_idx(best_idx)
    );

    always #5 clk = ~clk;

    // Datapath model configuration (written by the test thread only)
    logic [12:0] vals [64];
    int lat      = 1;
    int extra    = 0;
    int hang_idx = -1;

    // Model state and statistics (written by the model only)
    int phase = 0, cnt = 0, hold = 0;
    logic [IDX_W-1:0] cur = '0;
    logic prev_init = 1'b0, prev_ack = 1'b0;
    int init_cnt = 0, ack_cnt = 0, both_cnt = 0;
    int hold_cycles = 0, hold_bad = 0, run_hang = 0;
    int seq_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            phase    = 0;
            sad_done = 1'b0;
            prev_init = 1'b0;
            prev_ack  = 1'b0;
        end else begin
            if (sad_init && !prev_init) begin
                seq_q.push_back(int'(cand_idx));
                init_cnt++;
            end
            if (sad_ack && !prev_ack) ack_cnt++;
            if (sad_init && sad_ack) both_cnt++;
            if (sad_init && int'(cand_idx) == hang_idx) run_hang++;
            prev_init = sad_init;
            prev_ack  = sad_ack;
            case (phase)
                0: if (sad_init && int'(cand_idx) != hang_idx) begin
                    cur = cand_idx;
                    if (lat <= 1) begin
                        sad_done  = 1'b1;
                        sad_value = vals[cand_idx];
                        phase     = 2;
                    end else begin
                        cnt   = lat - 1;
                        phase = 1;
                    end
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        sad_done  = 1'b1;
                        sad_value = vals[cur];
                        phase     = 2;
                    end
                end
                2: if (sad_ack) begin
                    if (extra == 0) begin
                        sad_done = 1'b0;
                        phase    = 0;
                    end else begin
                        hold  = extra;
                        phase = 3;
                    end
                end
                3: begin
                    hold_cycles++;
                    if (!sad_ack || cand_idx != cur) hold_bad++;
                    hold--;
                    if (hold == 0) begin
                        sad_done = 1'b0;
                        phase    = 0;
                    end
                end
                default: phase = 0;
            endcase
        end
    end

    task automatic pulse_start(input logic [IDX_W:0] n);
        @(posedge clk); #1;
        num_cand = n;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic do_ack();
        @(posedge clk); #1;
        host_ack = 1'b1;
        @(posedge clk); #1;
        host_ack = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b0; start = 1'b0; host_ack = 1'b0; num_cand = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({sad_init, sad_ack, busy, done, err} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000", {sad_init, sad_ack, busy, done, err});
        else pass_cnt++;
        total_cnt++;
        if (best_sad !== 13'h1FFF) $display("FAIL reset_best_sad got %h want 1fff", best_sad);
        else pass_cnt++;
        total_cnt++;
        if (best_idx !== '0 || cand_idx !== '0)
            $display("FAIL reset_idx got best_idx=%0d cand_idx=%0d want 0 0", best_idx, cand_idx);
        else pass_cnt++;
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy || done || sad_init || sad_ack || err || best_sad !== 13'h1FFF) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL idle_stable got %0d bad cycles want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_run4();
        bit ok;
        int base_seq, base_init, base_ack, bad;
        vals[0] = 13'd100; vals[1] = 13'd40; vals[2] = 13'd75; vals[3] = 13'd40;
        lat = 2; extra = 0; hang_idx = -1;
        base_seq = seq_q.size(); base_init = init_cnt; base_ack = ack_cnt;
        pulse_start(7'd4);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL run4_busy got %b want 1", busy);
        else pass_cnt++;
        wait_done(200, ok);
        total_cnt++;
        if (!ok) $display("FAIL run4_timeout got done=0 want 1");
        else pass_cnt++;
        total_cnt++;
        if (best_sad !== 13'd40 || best_idx !== 6'd1)
            $display("FAIL run4_best got sad=%0d idx=%0d want 40 1", best_sad, best_idx);
        else pass_cnt++;
        total_cnt++;
        if (init_cnt - base_init != 4 || ack_cnt - base_ack != 4)
            $display("FAIL run4_pairs got init=%0d ack=%0d want 4 4",
                     init_cnt - base_init, ack_cnt - base_ack);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (seq_q.size() <= base_seq + i || seq_q[base_seq + i] != i) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL run4_cand_seq got %0d wrong entries want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0 || busy !== 1'b0)
            $display("FAIL run4_status got err=%b busy=%b want 0 0", err, busy);
        else pass_cnt++;
        do_ack();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL run4_ack got done=%b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        int base_init;
        base_init = init_cnt;
        pulse_start(7'd0);
        total_cnt++;
        if (done !== 1'b1) $display("FAIL zero_done got %b want 1", done);
        else pass_cnt++;
        total_cnt++;
        if (best_sad !== 13'h1FFF || best_idx !== '0)
            $display("FAIL zero_best got sad=%h idx=%0d want 1fff 0", best_sad, best_idx);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (init_cnt != base_init) $display("FAIL zero_no_init got %0d inits want 0", init_cnt - base_init);
        else pass_cnt++;
        do_ack();
    endtask

    task automatic test_watchdog();
        bit ok;
        int base_hang;
        vals[0] = 13'd50; vals[1] = 13'd30; vals[2] = 13'd10; vals[3] = 13'd5; vals[4] = 13'd1;
        lat = 1; extra = 0; hang_idx = 2;
        base_hang = run_hang;
        pulse_start(7'd5);
        wait_done(1000, ok);
        total_cnt++;
        if (!ok) $display("FAIL wdog_timeout got done=0 want 1");
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b1) $display("FAIL wdog_err got %b want 1", err);
        else pass_cnt++;
        total_cnt++;
        if (run_hang - base_hang != 255)
            $display("FAIL wdog_run_cycles got %0d want 255", run_hang - base_hang);
        else pass_cnt++;
        total_cnt++;
        if (best_sad !== 13'd30 || best_idx !== 6'd1)
            $display("FAIL wdog_best got sad=%0d idx=%0d want 30 1", best_sad, best_idx);
        else pass_cnt++;
        hang_idx = -1;
        do_ack();
    endtask

    task automatic test_mid_reset();
        bit ok;
        vals[0] = 13'd60; vals[1] = 13'd50; vals[2] = 13'd40; vals[3] = 13'd30; vals[4] = 13'd20;
        lat = 3; extra = 0;
        pulse_start(7'd5);
        total_cnt++;
        if (err !== 1'b0) $display("FAIL restart_err_clear got %b want 0", err);
        else pass_cnt++;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (sad_init && cand_idx == 6'd3) begin
                ok = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!ok) $display("FAIL mrst_reach_cand3 got no RUN on cand 3 want RUN");
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({sad_init, sad_ack, busy, done, err} !== 5'b0 || cand_idx !== '0 ||
            best_sad !== 13'h1FFF || best_idx !== '0)
            $display("FAIL mrst_async got flags=%b cand=%0d sad=%h idx=%0d want 00000 0 1fff 0",
                     {sad_init, sad_ack, busy, done, err}, cand_idx, best_sad, best_idx);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        vals[0] = 13'd9; vals[1] = 13'd7;
        pulse_start(7'd2);
        wait_done(200, ok);
        total_cnt++;
        if (!ok || best_sad !== 13'd7 || best_idx !== 6'd1)
            $display("FAIL mrst_rerun got done=%b sad=%0d idx=%0d want 1 7 1", done, best_sad, best_idx);
        else pass_cnt++;
        do_ack();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base_seq, base_init, base_hold, base_bad, bad;
        vals[0] = 13'd20; vals[1] = 13'd20; vals[2] = 13'd5;
        lat = 1; extra = 5;
        base_seq = seq_q.size(); base_init = init_cnt;
        base_hold = hold_cycles; base_bad = hold_bad;
        pulse_start(7'd3);
        repeat (3) @(posedge clk);
        #1;
        pulse_start(7'd1);
        wait_done(300, ok);
        total_cnt++;
        if (!ok || best_sad !== 13'd5 || best_idx !== 6'd2)
            $display("FAIL b2b_best got done=%b sad=%0d idx=%0d want 1 5 2", done, best_sad, best_idx);
        else pass_cnt++;
        total_cnt++;
        if (init_cnt - base_init != 3) $display("FAIL b2b_no_restart got %0d inits want 3", init_cnt - base_init);
        else pass_cnt++;
        total_cnt++;
        if (hold_cycles - base_hold != 15 || hold_bad != base_bad)
            $display("FAIL b2b_hold got held=%0d bad=%0d want 15 0",
                     hold_cycles - base_hold, hold_bad - base_bad);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 3; i++)
            if (seq_q.size() <= base_seq + i || seq_q[base_seq + i] != i) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL b2b_cand_seq got %0d wrong entries want 0", bad);
        else pass_cnt++;
        extra = 0;
        do_ack();
    endtask

    task automatic test_full_count();
        bit ok;
        int base_init;
        for (int i = 0; i < 64; i++) vals[i] = 13'(200 - i);
        lat = 1; extra = 0;
        base_init = init_cnt;
        pulse_start(7'd64);
        wait_done(1000, ok);
        total_cnt++;
        if (!ok || best_sad !== 13'd137 || best_idx !== 6'd63)
            $display("FAIL full_best got done=%b sad=%0d idx=%0d want 1 137 63", done, best_sad, best_idx);
        else pass_cnt++;
        total_cnt++;
        if (init_cnt - base_init != 64) $display("FAIL full_count got %0d inits want 64", init_cnt - base_init);
        else pass_cnt++;
        do_ack();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) vals[i] = '0;
        test_reset();
        test_run4();
        test_zero();
        test_watchdog();
        test_mid_reset();
        test_back_to_back();
        test_full_count();
        total_cnt++;
        if (both_cnt != 0) $display("FAIL init_ack_exclusive got %0d overlaps want 0", both_cnt);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "bench time limit");
    end

endmodule
